// File: rtl/ras_ckpt.sv
// Return address stack with speculative checkpoint/restore.
//
// The stack lives in a circular buffer: tos_q points at the top entry and
// cnt_q counts the valid entries, saturating at DEPTH. A push on a full stack
// wraps and silently overwrites the oldest entry. Popped entries are never
// cleared, which lets a restore bring back a deeper stack as long as the
// wrong path did not overwrite the entries below the repaired top.
//
// Request interface: flush_i, restore_i, push_i, pop_i and ckpt_i are
// single-cycle strobes sampled on every rising edge. There is no valid/ready
// handshake and no backpressure; every request is accepted in the cycle it is
// presented. Priority is flush, then restore, then push/pop/ckpt.
//
// DEPTH must be a power of two (>= 2) so that pointer arithmetic wraps
// naturally at PTR_W bits.
module ras_ckpt #(
    parameter int DEPTH   = 4,
    parameter int VLEN    = 64,
    parameter int NR_CKPT = 4
) (
    input  logic                                           clk_i,
    input  logic                                           rst_ni,
    input  logic                                           flush_i,
    input  logic                                           push_i,
    input  logic                                           pop_i,
    input  logic [VLEN-1:0]                                data_i,
    input  logic                                           ckpt_i,
    input  logic [((NR_CKPT > 1) ? $clog2(NR_CKPT) : 1)-1:0] ckpt_id_i,
    input  logic                                           restore_i,
    input  logic [((NR_CKPT > 1) ? $clog2(NR_CKPT) : 1)-1:0] restore_id_i,
    output logic [VLEN-1:0]                                ra_o,
    output logic                                           valid_o,
    output logic [$clog2(DEPTH+1)-1:0]                     count_o,
    output logic                                           overflow_o,
    output logic                                           underflow_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ID_W  = (NR_CKPT > 1) ? $clog2(NR_CKPT) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // ------------------------------------------------------------------
    // Live stack state
    // ------------------------------------------------------------------
    logic [VLEN-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] tos_q, tos_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Single write port into the buffer; at most one writer per cycle.
    logic             mem_we;
    logic [PTR_W-1:0] mem_waddr;
    logic [VLEN-1:0]  mem_wdata;

    // ------------------------------------------------------------------
    // Checkpoint slots: pointer, count and a copy of the top entry
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] slot_tos_q [NR_CKPT];
    logic [CNT_W-1:0] slot_cnt_q [NR_CKPT];
    logic [VLEN-1:0]  slot_top_q [NR_CKPT];

    logic [PTR_W-1:0] rd_tos;
    logic [CNT_W-1:0] rd_cnt;
    logic [VLEN-1:0]  rd_top;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic             do_restore;
    logic             do_stack;
    logic             do_push;
    logic             do_pop;
    logic             do_swap;
    logic             do_ckpt;
    logic             is_full;
    logic             is_empty;
    logic [VLEN-1:0]  top_q;

    // Flush masks everything; restore masks stack ops and checkpoints.
    assign do_restore = restore_i & ~flush_i;
    assign do_stack   = ~flush_i & ~restore_i;
    assign do_push    = do_stack & push_i & ~pop_i;
    assign do_pop     = do_stack & pop_i & ~push_i;
    assign do_swap    = do_stack & push_i & pop_i;
    assign do_ckpt    = do_stack & ckpt_i;

    assign is_full    = (cnt_q == CNT_FULL);
    assign is_empty   = (cnt_q == '0);
    assign top_q      = mem_q[tos_q];

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign valid_o     = ~is_empty;
    assign ra_o        = is_empty ? '0 : top_q;
    assign count_o     = cnt_q;
    // A push on a full stack is the only way to lose the oldest entry.
    assign overflow_o  = do_push & is_full;
    // A pop on an empty stack is reported and otherwise ignored.
    assign underflow_o = do_pop & is_empty;

    // Select the restore source slot; ids past the last slot read as empty.
    always_comb begin
        rd_tos = '0;
        rd_cnt = '0;
        rd_top = '0;
        for (int s = 0; s < NR_CKPT; s++) begin
            if (restore_id_i == ID_W'(s)) begin
                rd_tos = slot_tos_q[s];
                rd_cnt = slot_cnt_q[s];
                rd_top = slot_top_q[s];
            end
        end
    end

    // Next pointer/count and the single buffer write for this cycle.
    always_comb begin
        tos_d     = tos_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = tos_q;
        mem_wdata = data_i;
        if (flush_i) begin
            // Entries stay in the buffer but become invisible.
            tos_d = '0;
            cnt_d = '0;
        end else if (do_restore) begin
            // Re-install the saved top in case the wrong path overwrote it.
            tos_d     = rd_tos;
            cnt_d     = rd_cnt;
            mem_we    = 1'b1;
            mem_waddr = rd_tos;
            mem_wdata = rd_top;
        end else if (do_swap) begin
            // Return immediately followed by a call: replace the top in place.
            mem_we    = 1'b1;
            mem_waddr = tos_q;
            mem_wdata = data_i;
            cnt_d     = is_empty ? CNT_ONE : cnt_q;
        end else if (do_push) begin
            tos_d     = tos_q + PTR_ONE;
            mem_we    = 1'b1;
            mem_waddr = tos_q + PTR_ONE;
            mem_wdata = data_i;
            cnt_d     = is_full ? cnt_q : cnt_q + CNT_ONE;
        end else if (do_pop && !is_empty) begin
            // The popped entry is kept so a later restore can still use it.
            tos_d = tos_q - PTR_ONE;
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tos_q <= '0;
            cnt_q <= '0;
        end else begin
            tos_q <= tos_d;
            cnt_q <= cnt_d;
        end
    end

    // Return address buffer, one write per cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Checkpoint slots capture the pre-update state shown on the outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < NR_CKPT; s++) begin
                slot_tos_q[s] <= '0;
                slot_cnt_q[s] <= '0;
                slot_top_q[s] <= '0;
            end
        end else if (flush_i) begin
            for (int s = 0; s < NR_CKPT; s++) begin
                slot_tos_q[s] <= '0;
                slot_cnt_q[s] <= '0;
                slot_top_q[s] <= '0;
            end
        end else if (do_ckpt) begin
            for (int s = 0; s < NR_CKPT; s++) begin
                if (ckpt_id_i == ID_W'(s)) begin
                    slot_tos_q[s] <= tos_q;
                    slot_cnt_q[s] <= cnt_q;
                    slot_top_q[s] <= top_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_ras_ckpt.sv
// Self-checking bench for ras_ckpt: directed scenarios plus a randomized run
// against a behavioural model of the stack and its checkpoint slots.
module tb_ras_ckpt;

    localparam int DEPTH   = 4;
    localparam int VLEN    = 64;
    localparam int NR_CKPT = 4;
    localparam int ID_W    = 2;
    localparam int CNT_W   = 3;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic             flush_i, push_i, pop_i, ckpt_i, restore_i;
    logic [VLEN-1:0]  data_i;
    logic [ID_W-1:0]  ckpt_id_i, restore_id_i;
    logic [VLEN-1:0]  ra_o;
    logic             valid_o, overflow_o, underflow_o;
    logic [CNT_W-1:0] count_o;

    ras_ckpt #(.DEPTH(DEPTH), .VLEN(VLEN), .NR_CKPT(NR_CKPT)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .push_i      (push_i),
        .pop_i       (pop_i),
        .data_i      (data_i),
        .ckpt_i      (ckpt_i),
        .ckpt_id_i   (ckpt_id_i),
        .restore_i   (restore_i),
        .restore_id_i(restore_id_i),
        .ra_o        (ra_o),
        .valid_o     (valid_o),
        .count_o     (count_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o)
    );

    int vectors = 0;
    int miscompares = 0;

    // Flags observed during the request cycle, captured by the driver.
    logic obs_ovf, obs_udf;

    // ------------------------------------------------------------------
    // Reference model: circular buffer by index arithmetic
    // ------------------------------------------------------------------
    logic [VLEN-1:0] m_mem [DEPTH];
    int              m_tos, m_cnt;
    int              s_tos [NR_CKPT];
    int              s_cnt [NR_CKPT];
    logic [VLEN-1:0] s_top [NR_CKPT];
    logic            exp_ovf, exp_udf;
    logic [VLEN-1:0] exp_q [$];

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        for (int i = 0; i < NR_CKPT; i++) begin
            s_tos[i] = 0; s_cnt[i] = 0; s_top[i] = '0;
        end
        m_tos = 0; m_cnt = 0; exp_ovf = 0; exp_udf = 0;
    endfunction

    function automatic logic [VLEN-1:0] model_ra();
        return (m_cnt != 0) ? m_mem[m_tos] : '0;
    endfunction

    function automatic void model_step(input logic f, input logic pu, input logic po,
                                       input logic [VLEN-1:0] d, input logic ck, input int cid,
                                       input logic rs, input int rid);
        exp_ovf = 0;
        exp_udf = 0;
        if (f) begin
            m_tos = 0; m_cnt = 0;
            for (int i = 0; i < NR_CKPT; i++) begin
                s_tos[i] = 0; s_cnt[i] = 0; s_top[i] = '0;
            end
        end else if (rs) begin
            m_tos = s_tos[rid];
            m_cnt = s_cnt[rid];
            m_mem[m_tos] = s_top[rid];
        end else begin
            if (ck) begin
                s_tos[cid] = m_tos; s_cnt[cid] = m_cnt; s_top[cid] = m_mem[m_tos];
            end
            if (pu && po) begin
                m_mem[m_tos] = d;
                if (m_cnt == 0) m_cnt = 1;
            end else if (pu) begin
                exp_ovf = (m_cnt == DEPTH);
                m_tos = (m_tos + 1) % DEPTH;
                m_mem[m_tos] = d;
                if (m_cnt < DEPTH) m_cnt++;
            end else if (po) begin
                if (m_cnt == 0) exp_udf = 1;
                else begin
                    m_tos = (m_tos + DEPTH - 1) % DEPTH;
                    m_cnt--;
                end
            end
        end
    endfunction

    // ------------------------------------------------------------------
    // Driver tasks: inputs change 1 time unit after a rising edge
    // ------------------------------------------------------------------
    task automatic clear_inputs();
        flush_i = 0; push_i = 0; pop_i = 0; ckpt_i = 0; restore_i = 0;
        data_i = '0; ckpt_id_i = '0; restore_id_i = '0;
    endtask

    task automatic step(input logic f, input logic pu, input logic po, input logic [VLEN-1:0] d,
                        input logic ck, input int cid, input logic rs, input int rid);
        flush_i = f; push_i = pu; pop_i = po; data_i = d;
        ckpt_i = ck; ckpt_id_i = ID_W'(cid); restore_i = rs; restore_id_i = ID_W'(rid);
        #1;
        obs_ovf = overflow_o;
        obs_udf = underflow_o;
        model_step(f, pu, po, d, ck, cid, rs, rid);
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic do_push(input logic [VLEN-1:0] d); step(0, 1, 0, d, 0, 0, 0, 0); endtask
    task automatic do_pop();                          step(0, 0, 1, '0, 0, 0, 0, 0); endtask
    task automatic do_flush();                        step(1, 0, 0, '0, 0, 0, 0, 0); endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        clear_inputs();
        rst_ni = 0;
        #12;
        vectors++; if (ra_o !== '0) begin miscompares++; $display("FAIL reset_ra: got %0h expected 0", ra_o); end
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        vectors++; if (count_o !== '0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", count_o); end
        vectors++; if (overflow_o !== 1'b0 || underflow_o !== 1'b0) begin
            miscompares++; $display("FAIL reset_flags: got ovf=%b udf=%b expected 0 0", overflow_o, underflow_o);
        end
        model_reset();
        @(posedge clk); #3; rst_ni = 1;
        @(posedge clk); #1;
        do_pop();
        vectors++; if (obs_udf !== 1'b1) begin miscompares++; $display("FAIL reset_pop_udf: got %b expected 1", obs_udf); end
        vectors++; if (count_o !== '0 || valid_o !== 1'b0) begin
            miscompares++; $display("FAIL reset_pop_state: got count=%0d valid=%b expected 0 0", count_o, valid_o);
        end
    endtask

    task automatic test_lifo();
        do_flush();
        do_push(64'hA); do_push(64'hB); do_push(64'hC);
        vectors++; if (ra_o !== 64'hC || count_o !== 3'd3) begin
            miscompares++; $display("FAIL lifo_push: got ra=%0h count=%0d expected C 3", ra_o, count_o);
        end
        do_pop();
        vectors++; if (ra_o !== 64'hB || count_o !== 3'd2) begin
            miscompares++; $display("FAIL lifo_pop: got ra=%0h count=%0d expected B 2", ra_o, count_o);
        end
    endtask

    task automatic test_overflow();
        int exp_cnt;
        logic exp_flag;
        do_flush();
        for (int i = 1; i <= 5; i++) begin
            do_push(VLEN'(i));
            exp_flag = (i == 5);
            exp_cnt = (i < DEPTH) ? i : DEPTH;
            vectors++; if (obs_ovf !== exp_flag) begin
                miscompares++; $display("FAIL ovf_flag push %0d: got %b expected %b", i, obs_ovf, exp_flag);
            end
            vectors++; if (count_o !== CNT_W'(exp_cnt)) begin
                miscompares++; $display("FAIL ovf_count push %0d: got %0d expected %0d", i, count_o, exp_cnt);
            end
        end
        for (int k = 0; k < 4; k++) begin
            do_pop();
            if (k < 3) begin
                vectors++; if (ra_o !== VLEN'(4 - k)) begin
                    miscompares++; $display("FAIL wrap_pop %0d: got %0h expected %0h", k, ra_o, 4 - k);
                end
            end else begin
                vectors++; if (valid_o !== 1'b0) begin
                    miscompares++; $display("FAIL wrap_empty: got valid=%b expected 0", valid_o);
                end
            end
        end
        do_pop();
        vectors++; if (obs_udf !== 1'b1) begin miscompares++; $display("FAIL wrap_udf: got %b expected 1", obs_udf); end
    endtask

    task automatic test_push_pop();
        do_flush();
        do_push(64'hA); do_push(64'hB);
        step(0, 1, 1, 64'hF, 0, 0, 0, 0);
        vectors++; if (obs_ovf !== 1'b0 || obs_udf !== 1'b0) begin
            miscompares++; $display("FAIL swap_flags: got ovf=%b udf=%b expected 0 0", obs_ovf, obs_udf);
        end
        vectors++; if (ra_o !== 64'hF || count_o !== 3'd2) begin
            miscompares++; $display("FAIL swap_top: got ra=%0h count=%0d expected F 2", ra_o, count_o);
        end
        do_flush();
        step(0, 1, 1, 64'h7, 0, 0, 0, 0);
        vectors++; if (obs_udf !== 1'b0) begin miscompares++; $display("FAIL swap_empty_udf: got %b expected 0", obs_udf); end
        vectors++; if (ra_o !== 64'h7 || count_o !== 3'd1) begin
            miscompares++; $display("FAIL swap_empty: got ra=%0h count=%0d expected 7 1", ra_o, count_o);
        end
    endtask

    task automatic test_ckpt_repair();
        do_flush();
        do_push(64'hA); do_push(64'hB);
        step(0, 0, 0, '0, 1, 1, 0, 0);
        do_pop(); do_push(64'h2); do_push(64'h3);
        step(0, 1, 0, 64'h99, 1, 2, 1, 1);
        vectors++; if (ra_o !== 64'hB || count_o !== 3'd2) begin
            miscompares++; $display("FAIL ckpt_restore: got ra=%0h count=%0d expected B 2", ra_o, count_o);
        end
        do_pop();
        vectors++; if (ra_o !== 64'hA || count_o !== 3'd1) begin
            miscompares++; $display("FAIL ckpt_pop: got ra=%0h count=%0d expected A 1", ra_o, count_o);
        end
    endtask

    task automatic test_flush_priority();
        do_flush();
        do_push(64'h11); do_push(64'h22); do_push(64'h33);
        step(0, 0, 0, '0, 1, 2, 0, 0);
        step(1, 1, 0, 64'h44, 1, 3, 0, 0);
        vectors++; if (count_o !== '0 || valid_o !== 1'b0) begin
            miscompares++; $display("FAIL flush_state: got count=%0d valid=%b expected 0 0", count_o, valid_o);
        end
        vectors++; if (ra_o !== '0) begin miscompares++; $display("FAIL flush_ra: got %0h expected 0", ra_o); end
        step(0, 0, 0, '0, 0, 0, 1, 2);
        vectors++; if (count_o !== '0) begin miscompares++; $display("FAIL flush_restore: got count=%0d expected 0", count_o); end
    endtask

    task automatic test_async_reset();
        do_push(64'h5); do_push(64'h6);
        #3; rst_ni = 0; #1;
        vectors++; if (count_o !== '0 || valid_o !== 1'b0 || ra_o !== '0) begin
            miscompares++; $display("FAIL async_reset: got count=%0d valid=%b ra=%0h expected 0 0 0", count_o, valid_o, ra_o);
        end
        model_reset();
        @(posedge clk); #3; rst_ni = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic f, pu, po, ck, rs;
        int cid, rid, r;
        logic [VLEN-1:0] d, e;
        do_flush();
        for (int n = 0; n < 600; n++) begin
            r  = $urandom_range(0, 99);
            f  = (r < 3);
            rs = (r >= 3 && r < 13);
            pu = ($urandom_range(0, 99) < 55);
            po = ($urandom_range(0, 99) < 45);
            ck = ($urandom_range(0, 99) < 30);
            cid = $urandom_range(0, NR_CKPT - 1);
            rid = $urandom_range(0, NR_CKPT - 1);
            d = {$urandom(), $urandom()};
            step(f, pu, po, d, ck, cid, rs, rid);
            vectors++; if (obs_ovf !== exp_ovf) begin
                miscompares++; $display("FAIL rnd_ovf cycle %0d: got %b expected %b", n, obs_ovf, exp_ovf);
            end
            vectors++; if (obs_udf !== exp_udf) begin
                miscompares++; $display("FAIL rnd_udf cycle %0d: got %b expected %b", n, obs_udf, exp_udf);
            end
            exp_q.push_back(model_ra());
            e = exp_q.pop_front();
            vectors++; if (ra_o !== e) begin
                miscompares++; $display("FAIL rnd_ra cycle %0d: got %0h expected %0h", n, ra_o, e);
            end
            vectors++; if (count_o !== CNT_W'(m_cnt) || valid_o !== (m_cnt != 0)) begin
                miscompares++; $display("FAIL rnd_count cycle %0d: got count=%0d valid=%b expected %0d", n, count_o, valid_o, m_cnt);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Sequence and final report
    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_lifo();
        test_overflow();
        test_push_pop();
        test_ckpt_repair();
        test_flush_priority();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Bound the whole run in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
